// File: rtl/i2c_slave_phy.sv
// Byte-level I2C target for one fixed 7-bit address: filtered SDA/SCL, START/STOP
// detection, address ACK, RX/TX valid-ready streams and SCL stretching on backpressure.
module i2c_slave_phy #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oe,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_oe,
    output logic [7:0] rx_data_o,
    output logic       rx_first_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       addressed_o,
    output logic       stop_o,
    output logic       nack_o
);

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
        S_RD_LOAD, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic [1:0] r_sda_sync, r_scl_sync;
    logic [2:0] r_sda_taps, r_scl_taps;
    logic       r_sda_d, r_scl_d;
    logic       w_sda_f, w_scl_f;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_hold_cnt;
    logic       r_sda_next, r_sda_upd;
    logic       r_rw, r_first_arm, r_ack_pend, r_tx_loaded;

    assign sda_o = 1'b0;
    assign scl_o = 1'b0;

    assign w_sda_f = (r_sda_taps[0] & r_sda_taps[1]) | (r_sda_taps[0] & r_sda_taps[2]) |
                     (r_sda_taps[1] & r_sda_taps[2]);
    assign w_scl_f = (r_scl_taps[0] & r_scl_taps[1]) | (r_scl_taps[0] & r_scl_taps[2]) |
                     (r_scl_taps[1] & r_scl_taps[2]);

    assign w_scl_rise  = w_scl_f & ~r_scl_d;
    assign w_scl_fall  = ~w_scl_f & r_scl_d;
    assign w_start     = r_scl_d & w_scl_f & r_sda_d & ~w_sda_f;
    assign w_stop      = r_scl_d & w_scl_f & ~r_sda_d & w_sda_f;
    assign w_byte_done = w_scl_fall & (r_bit_cnt == 4'd8);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sda_sync <= '1;
            r_scl_sync <= '1;
            r_sda_taps <= '1;
            r_scl_taps <= '1;
            r_sda_d    <= 1'b1;
            r_scl_d    <= 1'b1;
        end else begin
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_taps <= {r_sda_taps[1:0], r_sda_sync[1]};
            r_scl_taps <= {r_scl_taps[1:0], r_scl_sync[1]};
            r_sda_d    <= w_sda_f;
            r_scl_d    <= w_scl_f;
        end
    end

    // SDA decisions are queued in r_sda_next and only reach the pad once the
    // hold counter started by the last SCL falling edge has run out.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx_shift  <= '0;
            r_hold_cnt  <= '0;
            r_sda_next  <= 1'b0;
            r_sda_upd   <= 1'b0;
            r_rw        <= 1'b0;
            r_first_arm <= 1'b0;
            r_ack_pend  <= 1'b0;
            r_tx_loaded <= 1'b0;
            sda_oe      <= 1'b0;
            scl_oe      <= 1'b0;
            rx_data_o   <= '0;
            rx_first_o  <= 1'b0;
            rx_valid_o  <= 1'b0;
            tx_ready_o  <= 1'b0;
            addressed_o <= 1'b0;
            stop_o      <= 1'b0;
            nack_o      <= 1'b0;
        end else begin
            stop_o     <= 1'b0;
            nack_o     <= 1'b0;
            tx_ready_o <= 1'b0;

            if (r_hold_cnt != 8'd0)
                r_hold_cnt <= r_hold_cnt - 8'd1;
            if (w_scl_fall)
                r_hold_cnt <= HOLD_INIT;
            if (r_hold_cnt == 8'd0 && r_sda_upd) begin
                sda_oe    <= r_sda_next;
                r_sda_upd <= 1'b0;
            end
            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;

            if (w_stop || w_start) begin
                sda_oe      <= 1'b0;
                scl_oe      <= 1'b0;
                r_sda_upd   <= 1'b0;
                r_ack_pend  <= 1'b0;
                r_tx_loaded <= 1'b0;
                addressed_o <= 1'b0;
                r_bit_cnt   <= '0;
                if (w_stop) begin
                    stop_o  <= addressed_o;
                    r_state <= S_IDLE;
                end else begin
                    r_state <= S_ADDR;
                end
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda_f};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                r_rw        <= r_shift[0];
                                r_sda_next  <= 1'b1;
                                r_sda_upd   <= 1'b1;
                                addressed_o <= 1'b1;
                                r_state     <= S_ADDR_ACK;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_next <= 1'b0;
                            r_sda_upd  <= 1'b1;
                            r_bit_cnt  <= '0;
                            if (r_rw) begin
                                scl_oe  <= 1'b1;
                                r_state <= S_RD_LOAD;
                            end else begin
                                r_first_arm <= 1'b1;
                                r_state     <= S_WR_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (!rx_valid_o && (w_byte_done || r_ack_pend)) begin
                            rx_data_o   <= r_shift;
                            rx_valid_o  <= 1'b1;
                            rx_first_o  <= r_first_arm;
                            r_first_arm <= 1'b0;
                            r_sda_next  <= 1'b1;
                            r_sda_upd   <= 1'b1;
                            r_ack_pend  <= 1'b0;
                            r_state     <= S_WR_ACK;
                        end else if (w_byte_done) begin
                            r_ack_pend <= 1'b1;
                            scl_oe     <= 1'b1;
                        end else if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda_f};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_oe && !r_sda_upd)
                            scl_oe <= 1'b0;
                        if (w_scl_fall) begin
                            r_sda_next <= 1'b0;
                            r_sda_upd  <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_state    <= S_WR_DATA;
                        end
                    end
                    S_RD_LOAD: begin
                        if (!r_tx_loaded) begin
                            if (tx_ready_o && tx_valid_i) begin
                                r_tx_shift  <= tx_data_i;
                                r_sda_next  <= ~tx_data_i[7];
                                r_sda_upd   <= 1'b1;
                                r_tx_loaded <= 1'b1;
                            end else if (tx_valid_i && !tx_ready_o) begin
                                tx_ready_o <= 1'b1;
                            end
                        end else if (!r_sda_upd) begin
                            scl_oe      <= 1'b0;
                            r_tx_loaded <= 1'b0;
                            r_bit_cnt   <= 4'd1;
                            r_state     <= S_RD_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_fall) begin
                            r_sda_upd <= 1'b1;
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_next <= 1'b0;
                                r_state    <= S_RD_ACK;
                            end else begin
                                r_sda_next <= ~r_tx_shift[6];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_bit_cnt  <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise && w_sda_f) begin
                            nack_o  <= 1'b1;
                            r_state <= S_IGNORE;
                        end else if (w_scl_fall) begin
                            scl_oe  <= 1'b1;
                            r_state <= S_RD_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_slave_phy.md
Name: i2c_slave_phy

Overview:
- Byte-level I2C target (responder) for one fixed 7-bit address; it is the bus-side counterpart of the team's I2C master PHY.
- Filters SDA/SCL, detects START/STOP, matches the address and ACKs it.
- Delivers written bytes on an RX valid/ready stream and fetches read bytes from a TX valid/ready stream.
- Stretches SCL whenever the fabric side is not ready; open-drain pads sit outside the block.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target answers to (no general call, no 10-bit)
HOLD_TICKS, 4, clk_i cycles after a filtered SCL falling edge before sda_oe may change (data hold time); range 1..255

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
sda_i  input  1  SDA pad input
sda_o  output  1  tied 1'b0
sda_oe  output  1  1 = pull SDA low
scl_i  input  1  SCL pad input
scl_o  output  1  tied 1'b0
scl_oe  output  1  1 = hold SCL low (stretch)
rx_data_o  output  8  received write byte
rx_first_o  output  1  rx_data_o is the first byte after the address
rx_valid_o  output  1  rx_data_o valid; held until accepted
rx_ready_i  input  1  sink accepts on rx_valid_o & rx_ready_i
tx_data_i  input  8  byte to return on a read
tx_valid_i  input  1  tx_data_i valid
tx_ready_o  output  1  one-cycle pulse; tx_data_i is taken when tx_valid_i & tx_ready_o
addressed_o  output  1  high from address ACK until STOP or repeated START
stop_o  output  1  one-cycle pulse on STOP while addressed
nack_o  output  1  one-cycle pulse when the master NACKs a read byte

Behaviour:
- Reset (asynchronous, rst_n_i low): state IDLE. sda_oe, scl_oe, rx_valid_o, rx_first_o, tx_ready_o, addressed_o, stop_o and nack_o are 0. rx_data_o is 8'h00. Filter registers are set to 1.
- Input conditioning: 2-FF synchroniser, then a 3-tap shift register with majority vote, giving filtered sda/scl. The filtered signal lags the pin by 4 clk_i cycles.
- Edges are taken from the filtered signals against their 1-cycle delayed copies.
- START = filtered SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- Bits are sampled on SCL rising edges, MSB first.
- sda_oe changes only HOLD_TICKS cycles after an SCL falling edge.
- scl_oe is asserted only while SCL is low: it is set on the cycle after the falling edge. It is released when the stretch condition clears.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE.
- IDLE:
  - START -> ADDR, bit counter cleared.
  - SDA/SCL activity without a START is ignored.
- ADDR: after 8 bits (address[6:0], R/W):
  - On a match: at the next falling edge assert sda_oe, go to ADDR_ACK and raise addressed_o.
  - On a mismatch -> IGNORE; sda_oe stays 0.
- ADDR_ACK, at the falling edge ending the ACK slot:
  - R/W=0: release SDA -> WR_DATA; rx_first_o is armed.
  - R/W=1 -> RD_LOAD.
- WR_DATA: after 8 bits, at the next falling edge:
  - If rx_valid_o is 0: load rx_data_o, set rx_valid_o, set rx_first_o (first byte only), assert sda_oe (ACK) -> WR_ACK.
  - If rx_valid_o is still 1: stretch SCL until the handshake, then load, ACK and release SCL.
- WR_ACK: at the falling edge release SDA -> WR_DATA.
- rx_valid_o clears on the cycle after rx_valid_o & rx_ready_i. Simultaneous accept and new load: the load wins and rx_valid_o stays 1.
- RD_LOAD: SCL is low and stretched.
  - When tx_valid_i is high, pulse tx_ready_o, latch the byte, drive bit7 (sda_oe = ~bit) after HOLD_TICKS, release SCL -> RD_DATA.
  - If tx_valid_i is already high on entry, no stretch occurs beyond the HOLD_TICKS window.
- RD_DATA: drive the next bit at each falling edge. After the 8th bit's falling edge, release SDA -> RD_ACK.
- RD_ACK: the master bit is sampled on the rising edge.
  - ACK (0) -> RD_LOAD at the falling edge.
  - NACK (1): pulse nack_o -> IGNORE.
- IGNORE: lines released; wait for START or STOP.
- STOP in any state:
  - Release both lines and go to IDLE.
  - If addressed_o was 1: pulse stop_o and clear addressed_o.
  - A pending rx_valid_o is kept.
- START in any non-IDLE state (repeated START): release lines, clear addressed_o, go to ADDR.
- The block never drives SDA while SCL is high, except when holding an ACK or data bit set up during the preceding low phase.

Test Plan:
- Write: START, 0xA0, 0x12, 0x34, STOP; rx_ready_i=1 -> ACK on all 3 bytes; rx 0x12 (first=1) then 0x34 (first=0); one stop_o pulse.
- Address mismatch: START, 0xA2, 0x55, STOP -> SDA never driven, no rx_valid_o, no stop_o, addressed_o stays 0.
- Read with stretch: START, 0xA1; tx_valid_i raised 200 cycles late with 0xC3 -> SCL held low until then; bus reads 0xC3; master NACK -> nack_o pulse, IGNORE until STOP.
- RX backpressure: two-byte write with rx_ready_i=0 until 500 cycles after byte 2 -> SCL stretched before the byte-2 ACK; both bytes received in order.
- Repeated START: write 0xA0, 0x07, Sr, 0xA1, read 0x99 + NACK, STOP -> rx 0x07, tx_ready_o pulsed once, stop_o once.
- Reset mid-read (rst_n_i low while driving a 0 bit) -> sda_oe and scl_oe are 0 within 1 cycle; next valid transaction works.
